// File: rtl/sky_execute_stage_hs.sv
// Execute stage with valid/ready handshakes on both sides, branch/jump resolution,
// multi-cycle ALU operations through a start/done handshake, flush and overflow reporting.
module sky_execute_stage_hs #(
    parameter int XLEN = 32,
    parameter int RA_W = 4,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] imm,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [OP_W-1:0] alu_op,
    input  logic [2:0]      branch_op,
    input  logic            multicycle,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] alu_operand_a,
    output logic [XLEN-1:0] alu_operand_b,
    output logic [OP_W-1:0] alu_operation,
    output logic            alu_start,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_done,
    input  logic            alu_zero_flag,
    input  logic            alu_overflow_flag,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_write_data,
    output logic [RA_W-1:0] wb_rd_addr,
    output logic            wb_mem_read,
    output logic            wb_mem_write,
    output logic            wb_reg_write,
    output logic            wb_overflow
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] lat_a_reg, lat_b_reg, lat_sd_reg;
    logic [OP_W-1:0] lat_op_reg;
    logic [RA_W-1:0] lat_rd_reg;
    logic            lat_mr_reg, lat_mw_reg, lat_rw_reg;

    logic            out_valid_reg, branch_taken_reg, wb_mr_reg, wb_mw_reg, wb_rw_reg, wb_ovf_reg;
    logic [XLEN-1:0] branch_target_reg, result_reg, mem_addr_reg, mem_wdata_reg;
    logic [RA_W-1:0] wb_rd_reg;

    logic            slot_free, accept, single_op, is_jump, taken_next, load_en;
    logic [XLEN-1:0] target_next, result_next, wdata_next;
    logic [RA_W-1:0] rd_next;
    logic            mr_next, mw_next, rw_next;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = (state_reg == IDLE) && slot_free && !flush;
    assign accept    = in_valid && in_ready;
    assign is_jump   = (branch_op == 3'd3) || (branch_op == 3'd4);
    // Any non-zero branch code forces the single-cycle path, even if multicycle is set.
    assign single_op = !multicycle || (branch_op != 3'd0);
    assign alu_start = accept && !single_op;

    assign alu_operand_a = (state_reg == BUSY) ? lat_a_reg  : operand_a;
    assign alu_operand_b = (state_reg == BUSY) ? lat_b_reg  : operand_b;
    assign alu_operation = (state_reg == BUSY) ? lat_op_reg : alu_op;

    always_comb begin
        taken_next = 1'b0;
        case (branch_op)
            3'd1:       taken_next = alu_zero_flag;
            3'd2:       taken_next = !alu_zero_flag;
            3'd3, 3'd4: taken_next = 1'b1;
            default:    taken_next = 1'b0;
        endcase
        target_next = (branch_op == 3'd4) ? {alu_result[XLEN-1:1], 1'b0} : pc_in + imm;
    end

    // Output payload comes from the live inputs in IDLE and from the latched op in BUSY.
    always_comb begin
        load_en     = 1'b0;
        result_next = alu_result;
        wdata_next  = store_data;
        rd_next     = rd_addr;
        mr_next     = mem_read;
        mw_next     = mem_write;
        rw_next     = reg_write;
        if (state_reg == BUSY) begin
            load_en    = alu_done && slot_free && !flush;
            wdata_next = lat_sd_reg;
            rd_next    = lat_rd_reg;
            mr_next    = lat_mr_reg;
            mw_next    = lat_mw_reg;
            rw_next    = lat_rw_reg;
        end else begin
            load_en = accept && single_op;
            if (is_jump) begin
                result_next = pc_in + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            lat_a_reg         <= '0;
            lat_b_reg         <= '0;
            lat_sd_reg        <= '0;
            lat_op_reg        <= '0;
            lat_rd_reg        <= '0;
            lat_mr_reg        <= 1'b0;
            lat_mw_reg        <= 1'b0;
            lat_rw_reg        <= 1'b0;
            out_valid_reg     <= 1'b0;
            branch_taken_reg  <= 1'b0;
            branch_target_reg <= '0;
            result_reg        <= '0;
            mem_addr_reg      <= '0;
            mem_wdata_reg     <= '0;
            wb_rd_reg         <= '0;
            wb_mr_reg         <= 1'b0;
            wb_mw_reg         <= 1'b0;
            wb_rw_reg         <= 1'b0;
            wb_ovf_reg        <= 1'b0;
        end else if (flush) begin
            state_reg        <= IDLE;
            out_valid_reg    <= 1'b0;
            branch_taken_reg <= 1'b0;
        end else begin
            branch_taken_reg <= accept && taken_next;
            if (accept && taken_next) begin
                branch_target_reg <= target_next;
            end
            if (alu_start) begin
                state_reg  <= BUSY;
                lat_a_reg  <= operand_a;
                lat_b_reg  <= operand_b;
                lat_sd_reg <= store_data;
                lat_op_reg <= alu_op;
                lat_rd_reg <= rd_addr;
                lat_mr_reg <= mem_read;
                lat_mw_reg <= mem_write;
                lat_rw_reg <= reg_write;
            end else if (load_en) begin
                state_reg <= IDLE;
            end
            if (load_en) begin
                out_valid_reg <= 1'b1;
                result_reg    <= result_next;
                mem_addr_reg  <= alu_result;
                mem_wdata_reg <= wdata_next;
                wb_rd_reg     <= rd_next;
                wb_mr_reg     <= mr_next;
                wb_mw_reg     <= mw_next;
                wb_rw_reg     <= rw_next;
                wb_ovf_reg    <= alu_overflow_flag;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign branch_taken   = branch_taken_reg;
    assign branch_target  = branch_target_reg;
    assign result         = result_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = mem_wdata_reg;
    assign wb_rd_addr     = wb_rd_reg;
    assign wb_mem_read    = wb_mr_reg;
    assign wb_mem_write   = wb_mw_reg;
    assign wb_reg_write   = wb_rw_reg;
    assign wb_overflow    = wb_ovf_reg;

endmodule

// File: tb/tb_sky_execute_stage_hs.sv
// Randomised scoreboard bench for the execute stage: a behavioural ALU and instruction
// model predict each memory-stage output, branch redirect, start pulse and ready level.
module tb_sky_execute_stage_hs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready, multicycle, mem_read, mem_write, reg_write;
    logic [31:0] pc_in, operand_a, operand_b, imm, store_data;
    logic [3:0]  rd_addr, alu_op;
    logic [2:0]  branch_op;
    logic [31:0] alu_operand_a, alu_operand_b, alu_result, branch_target;
    logic [3:0]  alu_operation, wb_rd_addr;
    logic        alu_start, alu_done, alu_zero_flag, alu_overflow_flag, branch_taken;
    logic        out_valid, out_ready, wb_mem_read, wb_mem_write, wb_reg_write, wb_overflow;
    logic [31:0] result, mem_addr, mem_write_data;

    sky_execute_stage_hs #(.XLEN(32), .RA_W(4), .OP_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
        .rd_addr(rd_addr), .alu_op(alu_op), .branch_op(branch_op), .multicycle(multicycle),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .store_data(store_data),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_operation(alu_operation),
        .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
        .alu_zero_flag(alu_zero_flag), .alu_overflow_flag(alu_overflow_flag),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .wb_rd_addr(wb_rd_addr), .wb_mem_read(wb_mem_read),
        .wb_mem_write(wb_mem_write), .wb_reg_write(wb_reg_write), .wb_overflow(wb_overflow)
    );

    typedef struct {
        logic [31:0] res, addr, wdata, target;
        logic [3:0]  rd;
        logic [3:0]  ctrl;   // {mem_read, mem_write, reg_write, overflow}
        logic        taken;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 1;   // 0 random, 1 always ready, 2 stalled
    int   next_lat = 3;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            default: return a ^ ~b;
        endcase
    endfunction

    function automatic logic alu_ovf(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] s;
        s = alu_f(a, b, op);
        if (op == 4'd0) return (a[31] == b[31]) && (s[31] != a[31]);
        if (op == 4'd1) return (a[31] != b[31]) && (s[31] != a[31]);
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im, input logic [31:0] sd, input logic [3:0] op,
                                   input logic [3:0] rd, input logic [2:0] bop,
                                   input logic mr, input logic mw, input logic rw);
        exp_t e;
        logic [31:0] r;
        r       = alu_f(a, b, op);
        e.res   = (bop == 3'd3 || bop == 3'd4) ? pc + 32'd4 : r;
        e.addr  = r;
        e.wdata = sd;
        e.rd    = rd;
        e.ctrl  = {mr, mw, rw, alu_ovf(a, b, op)};
        e.taken = (bop == 3'd1 && r == 0) || (bop == 3'd2 && r != 0) || bop == 3'd3 || bop == 3'd4;
        e.target = (bop == 3'd4) ? (r & 32'hFFFF_FFFE) : pc + im;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // External ALU: combinational in single-cycle use, latency-programmable for start/done ops.
    logic        busy_m = 0, mc_active = 0, stale = 0;
    int          mc_cnt = 0, stale_cnt = 0;
    logic [31:0] lat_a = 0, lat_b = 0;
    logic [3:0]  lat_op = 0;
    logic        am_reset, am_flush, am_start, am_acc_mc, am_consume;
    logic [31:0] am_a, am_b;
    logic [3:0]  am_op;

    assign alu_result        = alu_done ? alu_f(lat_a, lat_b, lat_op) : alu_f(alu_operand_a, alu_operand_b, alu_operation);
    assign alu_zero_flag     = (alu_result == 32'd0);
    assign alu_overflow_flag = alu_done ? alu_ovf(lat_a, lat_b, lat_op) : alu_ovf(alu_operand_a, alu_operand_b, alu_operation);

    initial alu_done = 1'b0;

    always begin
        @(negedge clk);
        am_reset   = reset;
        am_flush   = flush;
        am_start   = alu_start;
        am_acc_mc  = in_valid && in_ready && multicycle && branch_op == 3'd0;
        am_consume = alu_done && busy_m && (!out_valid || out_ready) && !flush && !reset;
        am_a = operand_a; am_b = operand_b; am_op = alu_op;
        @(posedge clk);
        #1;
        if (am_reset) begin
            mc_active = 0; alu_done = 0; busy_m = 0; stale = 0;
        end else begin
            if (am_consume) begin
                alu_done = 0; mc_active = 0; busy_m = 0;
            end else if (am_flush) begin
                busy_m = 0;
                if (mc_active) stale = 1;
            end
            if (mc_active && !alu_done) begin
                mc_cnt--;
                if (mc_cnt <= 0) alu_done = 1;
            end else if (alu_done && stale) begin
                stale_cnt--;
                if (stale_cnt <= 0) begin
                    alu_done = 0; mc_active = 0; stale = 0;
                end
            end
            if (am_start) begin
                mc_active = 1; alu_done = 0; mc_cnt = next_lat; stale_cnt = 3;
                lat_a = am_a; lat_b = am_b; lat_op = am_op;
                busy_m = am_acc_mc;
                stale  = !am_acc_mc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: pops the scoreboard on each memory-stage handshake and tracks redirects.
    logic        exp_bt = 0;
    logic [31:0] exp_tgt = 0;
    logic        mon_acc;
    exp_t        mon_e, mon_m;

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            exp_bt  = 0;
            exp_tgt = 0;
        end else begin
            chk("in_ready", in_ready, !busy_m && (!out_valid || out_ready) && !flush);
            mon_acc = in_valid && in_ready;
            chk("alu_start", alu_start, mon_acc && multicycle && branch_op == 3'd0);
            chk("alu_operand_a", alu_operand_a, busy_m ? lat_a : operand_a);
            chk("alu_operand_b", alu_operand_b, busy_m ? lat_b : operand_b);
            chk("alu_operation", alu_operation, busy_m ? lat_op : alu_op);
            chk("branch_taken", branch_taken, exp_bt);
            chk("branch_target", branch_target, exp_tgt);
            if (out_valid && sb_q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else if (out_valid && out_ready && !flush) begin
                mon_e = sb_q.pop_front();
                chk("sb_result", result, mon_e.res);
                chk("sb_mem_addr", mem_addr, mon_e.addr);
                chk("sb_wdata", mem_write_data, mon_e.wdata);
                chk("sb_rd", wb_rd_addr, mon_e.rd);
                chk("sb_ctrl", {wb_mem_read, wb_mem_write, wb_reg_write, wb_overflow}, mon_e.ctrl);
            end
            if (flush) sb_q.delete();
            mon_m  = model(pc_in, operand_a, operand_b, imm, store_data, alu_op, rd_addr, branch_op,
                           mem_read, mem_write, reg_write);
            exp_bt = mon_acc && mon_m.taken;
            if (exp_bt) exp_tgt = mon_m.target;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] sd, input logic [3:0] op,
                        input logic [3:0] rd, input logic [2:0] bop, input logic mc,
                        input logic mr, input logic mw, input logic rw, input logic fl_first);
        bit ok = 0;
        for (int c = 0; c < 60 && (mc_active || busy_m); c++) tick(1);
        pc_in = pc; operand_a = a; operand_b = b; imm = im; store_data = sd; alu_op = op;
        rd_addr = rd; branch_op = bop; multicycle = mc; mem_read = mr; mem_write = mw;
        reg_write = rw; in_valid = 1'b1; flush = fl_first;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (in_valid && in_ready && !reset) begin
                sb_q.push_back(model(pc, a, b, im, sd, op, rd, bop, mr, mw, rw));
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_ctrl"}, {wb_rd_addr, wb_mem_read, wb_mem_write, wb_reg_write, wb_overflow}, 0);
        chk({tag, "_branch"}, {branch_taken, branch_target}, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 1;
        pc_in = 0; operand_a = 0; operand_b = 0; imm = 0; store_data = 0; rd_addr = 0;
        alu_op = 0; branch_op = 0; multicycle = 0; mem_read = 0; mem_write = 0; reg_write = 0;
        tick(3);
        reset = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single-cycle ADD
        send(32'h0, 32'd5, 32'd7, 0, 0, 4'd0, 4'd3, 3'd0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 32'd12);
        chk("add_rd", {wb_rd_addr, wb_reg_write}, {4'd3, 1'b1});
        tick(3);

        // Backpressure: the second instruction waits for out_ready
        ready_mode = 2;
        tick(1);
        send(32'h10, 32'd1, 32'd2, 0, 32'h55, 4'd0, 4'd5, 3'd0, 0, 0, 1, 0, 0);
        fork
            send(32'h14, 32'd10, 32'd20, 0, 32'h66, 4'd0, 4'd6, 3'd0, 0, 1, 0, 1, 0);
            begin
                tick(3);
                @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_hold_result", result, 32'd3);
                @(posedge clk);
                #1;
                ready_mode = 1;
            end
        join
        tick(3);

        // Multi-cycle op completing after four cycles
        next_lat = 4;
        send(32'h20, 32'hDE00, 32'hAD, 0, 0, 4'd0, 4'd7, 3'd0, 1, 0, 0, 1, 0);
        tick(8);

        // Branches
        send(32'h100, 32'd9, 32'd9, 32'h20, 0, 4'd1, 4'd0, 3'd1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("beq_taken", {branch_taken, branch_target}, {1'b1, 32'h120});
        @(posedge clk);
        #1;
        send(32'h200, 32'd9, 32'd9, 32'h20, 0, 4'd1, 4'd0, 3'd2, 0, 0, 0, 0, 0);
        send(32'h40, 32'h200, 32'd3, 32'h0, 0, 4'd0, 4'd1, 3'd4, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("jalr_target", branch_target, 32'h202);
        chk("jalr_result", result, 32'h44);
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFC, 32'd1, 32'd1, 32'd8, 0, 4'd0, 4'd1, 3'd3, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("jal_wrap_target", branch_target, 32'h4);
        @(posedge clk);
        #1;
        tick(2);

        // Flush while BUSY, then a stale alu_done
        next_lat = 6;
        send(32'h300, 32'd100, 32'd1, 0, 0, 4'd1, 4'd2, 3'd0, 1, 0, 0, 1, 0);
        tick(2);
        flush = 1;
        tick(1);
        flush = 0;
        tick(12);

        // Flush coincident with in_valid
        send(32'h310, 32'd4, 32'd4, 0, 0, 4'd4, 4'd9, 3'd0, 0, 0, 0, 1, 1);
        tick(2);

        // Randomised traffic
        ready_mode = 0;
        for (int i = 0; i < 250; i++) begin
            logic [2:0] bop;
            bop = 3'($urandom_range(0, 9) > 7 ? 0 : $urandom_range(0, 7));
            next_lat = $urandom_range(1, 5);
            send($urandom, ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom, ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom,
                 $urandom, $urandom, 4'($urandom_range(0, 7)), 4'($urandom), bop,
                 $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) begin
                tick($urandom_range(0, 2));
                flush = 1;
                tick(1);
                flush = 0;
            end
            tick($urandom_range(0, 2));
        end

        // Reset while an output is held, then reset mid-BUSY
        ready_mode = 2;
        tick(3);
        send(32'h500, 32'h33, 32'd1, 0, 32'h77, 4'd0, 4'd4, 3'd0, 0, 1, 1, 1, 0);
        tick(1);
        reset_check("rst_held");
        ready_mode = 1;
        next_lat = 10;
        send(32'h600, 32'd8, 32'd2, 0, 0, 4'd0, 4'd5, 3'd0, 1, 0, 0, 1, 0);
        tick(2);
        reset_check("rst_busy");

        ready_mode = 1;
        tick(20);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sky_execute_stage_hs.md
Name: sky_execute_stage_hs

Overview:
- Parametrised execute stage of the XU pipeline; sits between decode and memory stages.
- Valid/ready handshakes on both sides replace the global stall input.
- Drives the external ALU. Adds branch/jump resolution, multi-cycle ALU operations via a start/done handshake, pipeline flush, and overflow reporting.

Parameters:
XLEN, 32, datapath/PC width
RA_W, 4, register address width
OP_W, 4, ALU operation code width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  kill in-flight/held instruction
in_valid  in  1  decode presents instruction
in_ready  out  1  stage accepts this cycle
pc_in  in  XLEN  instruction PC
operand_a  in  XLEN  ALU operand A
operand_b  in  XLEN  ALU operand B
imm  in  XLEN  branch/jump offset
rd_addr  in  RA_W  destination register
alu_op  in  OP_W  ALU operation
branch_op  in  3  0 none, 1 BEQ, 2 BNE, 3 JAL, 4 JALR, 5-7 treated as none
multicycle  in  1  op needs ALU start/done handshake
mem_read, mem_write, reg_write  in  1 each  control bits
store_data  in  XLEN  store data
alu_operand_a, alu_operand_b  out  XLEN  ALU operands
alu_operation  out  OP_W  ALU op code
alu_start  out  1  one-cycle start for multi-cycle op
alu_result  in  XLEN  ALU result
alu_done  in  1  multi-cycle result valid (level, held until consumed)
alu_zero_flag, alu_overflow_flag  in  1 each  ALU flags
branch_taken  out  1  registered redirect pulse
branch_target  out  XLEN  redirect address
out_valid  out  1  memory-stage output valid
out_ready  in  1  memory stage accepts
result, mem_addr, mem_write_data  out  XLEN  registered outputs
wb_rd_addr  out  RA_W
wb_mem_read, wb_mem_write, wb_reg_write, wb_overflow  out  1 each

Behaviour:
- Reset (synchronous, wins over everything): state IDLE; all registered outputs 0, out_valid 0, branch_taken 0, branch_target 0; alu_start 0; latched-op register 0.
- slot_free = !out_valid || out_ready.
- in_ready = (state==IDLE) && slot_free && !flush.
- Accept = in_valid && in_ready.
- FSM IDLE:
  - Operands/op drive the ALU combinationally from the inputs.
  - Single-cycle accept (multicycle=0, or branch_op!=0; branch_op overrides multicycle): output registers load next edge, out_valid=1. Latency 1 cycle.
- FSM multi-cycle accept:
  - alu_start=1 combinationally in the accept cycle only.
  - Inputs latch into the op register; go BUSY.
- FSM BUSY:
  - ALU operands and op are driven from the latched register.
  - When alu_done && slot_free: load outputs from alu_result plus latched controls, out_valid=1, return to IDLE.
  - alu_done while the slot is blocked: stay BUSY and wait.
- Output load:
  - result = alu_result, or pc+4 for JAL/JALR.
  - mem_addr = alu_result; mem_write_data = store_data.
  - wb_* copy the control bits; wb_overflow = alu_overflow_flag.
- out_valid clears on out_ready unless a new load occurs the same edge.
- Branch resolution (on accept only):
  - BEQ taken if alu_zero_flag; BNE taken if !alu_zero_flag; JAL/JALR always taken.
  - Target = pc_in+imm (BEQ/BNE/JAL) or alu_result with bit0 cleared (JALR).
  - All sums are modulo 2^XLEN.
  - branch_taken is registered: high exactly one cycle after accept. branch_target is held until the next taken branch.
- Flush (synchronous):
  - Next edge: out_valid=0, BUSY→IDLE, branch_taken=0.
  - in_ready=0 and alu_start=0 during the flush cycle. Pending alu_done is ignored.
  - reset > flush > normal operation.

Test Plan:
- Single-cycle ADD: in_valid=1, operand_a=5, operand_b=7, alu_result=12, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, result=12, wb_rd_addr=3, wb_reg_write=1.
- Backpressure: out_valid=1, out_ready=0, new in_valid -> in_ready=0 and outputs held. Raise out_ready -> instruction accepted, loaded one cycle later, no loss or duplication.
- Multi-cycle: multicycle=1 accepted -> alu_start pulse 1 cycle, in_ready=0. alu_done with result 0xDEAD after 4 cycles -> result=0xDEAD next edge, returns to IDLE, ALU operands stable throughout BUSY.
- Branches:
  - BEQ pc=0x100, imm=0x20, zero=1 -> branch_taken pulse 1 cycle, target 0x120.
  - BNE with zero=1 -> not taken.
  - JALR alu_result=0x203 -> target 0x202, result=pc+4.
  - pc=0xFFFFFFFC, imm=8 -> target 0x4.
- Flush: flush while BUSY -> out_valid stays 0, state IDLE, no alu_start. Later alu_done is ignored. Flush coincident with in_valid -> input not accepted.
- Reset mid-BUSY with out_valid=1 -> all outputs 0 next edge, in_ready=1 the following cycle.
